// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: instruction field layout,
// control sub-op encodings and FSM state encoding.
package core_sequencer_pkg;

    typedef logic [1:0] state_t;

    // opcode classes, field [15:14]
    localparam logic [1:0] CLASS_LOAD = 2'b00;
    localparam logic [1:0] CLASS_ALU2 = 2'b01;
    localparam logic [1:0] CLASS_ALU1 = 2'b10;
    localparam logic [1:0] CLASS_MISC = 2'b11;

    // control sub-ops, field [6:5]
    localparam logic [1:0] SUBOP_END      = 2'b00;
    localparam logic [1:0] SUBOP_LOOP_SET = 2'b01;
    localparam logic [1:0] SUBOP_LOOP_END = 2'b10;
    localparam logic [1:0] SUBOP_WAIT     = 2'b11;

    localparam int CLASS_MSB = 15;
    localparam int CLASS_LSB = 14;
    localparam int STORE_BIT = 8;
    localparam int CTRL_BIT  = 7;
    localparam int SUBOP_MSB = 6;
    localparam int SUBOP_LSB = 5;
    localparam int IMM_MSB   = 4;
    localparam int IMM_LSB   = 0;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_WAIT  = 2'd3;

    // Local store shares class MISC but has the store bit set, so it is
    // still broadcast to the cores.
    function automatic logic is_ctrl_word(input logic [15:0] word);
        return (word[CLASS_MSB:CLASS_LSB] == CLASS_MISC) &&
               !word[STORE_BIT] && word[CTRL_BIT];
    endfunction

endpackage

// File: rtl/seq_loop_unit.sv
// Single-level hardware loop: remembers the loop body start and the
// remaining iteration count, and decides whether a LOOP_END branches back.
module seq_loop_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  loop_set,
    input  logic                  loop_end,
    input  logic [4:0]            loop_imm,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  branch_taken,
    output logic [ADDR_WIDTH-1:0] branch_pc
);

    logic [ADDR_WIDTH-1:0] loop_start;
    logic [4:0]            loop_cnt;
    logic                  loop_active;

    assign branch_taken = loop_end && loop_active && (loop_cnt != 5'd0);
    assign branch_pc    = loop_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_start  <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
        end else if (clear) begin
            loop_active <= 1'b0;
        end else if (loop_set) begin
            // a nested LOOP_SET simply replaces the current loop
            loop_start  <= pc + 1'b1;
            loop_cnt    <= loop_imm;
            loop_active <= 1'b1;
        end else if (loop_end && loop_active) begin
            if (loop_cnt != 5'd0) begin
                loop_cnt <= loop_cnt - 1'b1;
            end else begin
                loop_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Fetches instructions over a valid handshake, broadcasts datapath words to
// the core array with an execute strobe and consumes control words locally.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no program running, waiting for start
//   ST_FETCH | prog_req high at pc, waiting for prog_valid
//   ST_ISSUE | execute strobe for the latched opcode, then pc+1
//   ST_WAIT  | stalled for a WAIT count, no fetch and no execute
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic                  prog_req,
    input  logic [15:0]           prog_data,
    input  logic                  prog_valid,
    output logic [15:0]           opcode,
    output logic                  execute,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pc
);

    state_t                state;
    logic [4:0]            wait_cnt;

    logic                  fetch_hit;
    logic                  word_is_ctrl;
    logic                  ctrl_hit;
    logic [1:0]            sub_op;
    logic [4:0]            imm;
    logic                  loop_set;
    logic                  loop_end;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic                  at_last;
    logic [ADDR_WIDTH-1:0] adv_pc;
    state_t                adv_state;

    assign prog_addr = pc;
    assign prog_req  = (state == ST_FETCH);
    assign execute   = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    assign fetch_hit    = (state == ST_FETCH) && prog_valid && !abort;
    assign word_is_ctrl = is_ctrl_word(prog_data);
    assign ctrl_hit     = fetch_hit && word_is_ctrl;
    assign sub_op       = prog_data[SUBOP_MSB:SUBOP_LSB];
    assign imm          = prog_data[IMM_MSB:IMM_LSB];
    assign loop_set     = ctrl_hit && (sub_op == SUBOP_LOOP_SET);
    assign loop_end     = ctrl_hit && (sub_op == SUBOP_LOOP_END);

    // Stepping past the last address ends the program instead of wrapping.
    assign at_last   = (pc == {ADDR_WIDTH{1'b1}});
    assign adv_pc    = at_last ? pc : pc + 1'b1;
    assign adv_state = at_last ? ST_IDLE : ST_FETCH;

    seq_loop_unit #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_loop (
        .clk          (clk),
        .rst          (rst),
        .clear        (abort),
        .loop_set     (loop_set),
        .loop_end     (loop_end),
        .loop_imm     (imm),
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            opcode   <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pc    <= START_ADDR;
                            state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (prog_valid) begin
                            if (!word_is_ctrl) begin
                                opcode <= prog_data;
                                state  <= ST_ISSUE;
                            end else begin
                                case (sub_op)
                                    SUBOP_END: begin
                                        done  <= 1'b1;
                                        state <= ST_IDLE;
                                    end
                                    SUBOP_LOOP_END: begin
                                        if (branch_taken) begin
                                            pc    <= branch_pc;
                                            state <= ST_FETCH;
                                        end else begin
                                            pc    <= adv_pc;
                                            state <= adv_state;
                                            done  <= at_last;
                                        end
                                    end
                                    SUBOP_WAIT: begin
                                        if (imm != 5'd0) begin
                                            wait_cnt <= imm;
                                            state    <= ST_WAIT;
                                        end else begin
                                            pc    <= adv_pc;
                                            state <= adv_state;
                                            done  <= at_last;
                                        end
                                    end
                                    default: begin
                                        pc    <= adv_pc;
                                        state <= adv_state;
                                        done  <= at_last;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ISSUE: begin
                        pc    <= adv_pc;
                        state <= adv_state;
                        done  <= at_last;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == 5'd1) begin
                            pc    <= adv_pc;
                            state <= adv_state;
                            done  <= at_last;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: an instruction-level interpreter predicts the
// cycle of every execute strobe and of the done pulse for each program.
module tb_core_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  prog_addr;
    logic        prog_req;
    logic [15:0] prog_data;
    logic        prog_valid;
    logic [15:0] opcode;
    logic        execute;
    logic        busy;
    logic        done;
    logic [7:0]  pc;

    core_sequencer #(
        .ADDR_WIDTH (8),
        .START_ADDR (8'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .prog_addr  (prog_addr),
        .prog_req   (prog_req),
        .prog_data  (prog_data),
        .prog_valid (prog_valid),
        .opcode     (opcode),
        .execute    (execute),
        .busy       (busy),
        .done       (done),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [15:0] mem [0:255];
    int          lat [0:4095];
    int          fidx;
    int          wcnt;
    logic [7:0]  held_addr;
    logic [15:0] pq [$];

    int          ex_cyc [$];
    logic [15:0] ex_op [$];
    int          dn_q [$];

    int          exp_cyc [$];
    logic [15:0] exp_op [$];
    int          exp_done;
    logic [15:0] last_op;

    // interpreter's persistent loop registers
    bit m_act;
    int m_cnt;
    int m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (execute) begin
                ex_cyc.push_back(cyc - t0);
                ex_op.push_back(opcode);
            end
            if (done) dn_q.push_back(cyc - t0);
        end
    end

    // program memory with a per-fetch latency taken from lat[]
    initial begin
        prog_valid = 1'b0;
        prog_data  = '0;
        wcnt       = 0;
        fidx       = 0;
        held_addr  = '0;
        forever begin
            @(negedge clk);
            prog_valid = 1'b0;
            if (prog_req) begin
                if (wcnt == 0) held_addr = prog_addr;
                else check("addr_hold", 32'(prog_addr), 32'(held_addr));
                if (wcnt >= lat[fidx & 4095]) begin
                    prog_valid = 1'b1;
                    prog_data  = mem[prog_addr];
                    wcnt       = 0;
                    fidx++;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    function automatic logic [15:0] rand_dp();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:14] == 2'b11 && !w[8] && w[7]) w[8] = 1'b1;
        return w;
    endfunction

    task automatic set_lat(input int mode);
        for (int i = 0; i < 4096; i++) lat[i] = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 16'hC080;
        for (int i = 0; i < pq.size() && i < 256; i++) mem[i] = pq[i];
    endtask

    task automatic clear_obs();
        ex_cyc.delete();
        ex_op.delete();
        dn_q.delete();
    endtask

    // Walks the program word by word; time is counted in cycles relative to
    // the cycle in which start is sampled, first fetch at cycle 1.
    task automatic model_run();
        int p, t, v, f, steps, n;
        logic [15:0] w;
        bit fin;
        exp_cyc.delete();
        exp_op.delete();
        exp_done = -1;
        p = 0; t = 1; f = 0; fin = 0; steps = 0;
        while (!fin && steps < 4000) begin
            steps++;
            w = mem[p];
            v = t + lat[f & 4095];
            f++;
            if (!(w[15:14] == 2'b11 && !w[8] && w[7])) begin
                exp_cyc.push_back(v + 1);
                exp_op.push_back(w);
                if (p == 255) begin exp_done = v + 2; fin = 1; end
                else begin p++; t = v + 2; end
            end else begin
                n = int'(w[4:0]);
                case (w[6:5])
                    2'b00: begin exp_done = v + 1; fin = 1; end
                    2'b01: begin
                        m_cnt = n; m_start = (p + 1) % 256; m_act = 1;
                        if (p == 255) begin exp_done = v + 1; fin = 1; end
                        else begin p++; t = v + 1; end
                    end
                    2'b10: begin
                        if (m_act && m_cnt != 0) begin
                            m_cnt--; p = m_start; t = v + 1;
                        end else begin
                            m_act = 0;
                            if (p == 255) begin exp_done = v + 1; fin = 1; end
                            else begin p++; t = v + 1; end
                        end
                    end
                    default: begin
                        if (p == 255) begin exp_done = v + 1 + n; fin = 1; end
                        else begin p++; t = v + 1 + n; end
                    end
                endcase
            end
        end
    endtask

    task automatic run_program(input int lat_mode, input bit inject_start);
        int limit, inj;
        load_prog();
        set_lat(lat_mode);
        model_run();
        @(negedge clk);
        fidx = 0;
        clear_obs();
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        limit = (exp_done > 0) ? exp_done + 6 : 3000;
        inj = int'($urandom_range(2, 20));
        for (int k = 2; k < limit; k++) begin
            @(negedge clk);
            start = inject_start && (k == inj) && busy;
        end
        start = 1'b0;
        check("exec_count", 32'(ex_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < ex_cyc.size(); i++) begin
            check("exec_cycle", 32'(ex_cyc[i]), 32'(exp_cyc[i]));
            check("exec_opcode", 32'(ex_op[i]), 32'(exp_op[i]));
        end
        check("done_count", 32'(dn_q.size()), 32'd1);
        check("done_cycle", 32'((dn_q.size() > 0) ? dn_q[0] : 0), 32'(exp_done));
        check("busy_after", 32'(busy), 32'd0);
        if (exp_op.size() > 0) last_op = exp_op[exp_op.size() - 1];
    endtask

    task automatic do_abort(input int l);
        pq = '{16'h4000, 16'hC080};
        load_prog();
        set_lat(l);
        @(negedge clk);
        fidx = 0;
        clear_obs();
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_fetch_addr", 32'(prog_addr), 32'd0);
        if (l > 0) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req", 32'(prog_req), 32'd0);
        check("abort_opcode", 32'(opcode), 32'(last_op));
        repeat (6) @(negedge clk);
        check("abort_done", 32'(dn_q.size()), 32'd0);
        check("abort_exec", 32'(ex_cyc.size()), 32'd0);
        m_act = 0;
    endtask

    task automatic gen_random();
        int kind, nb;
        pq.delete();
        while (pq.size() < 40) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) pq.push_back(rand_dp());
            else if (kind == 6) pq.push_back(16'hC0E0 | 16'($urandom_range(0, 5)));
            else if (kind == 7) pq.push_back(16'hC0C0);
            else begin
                pq.push_back(16'hC0A0 | 16'($urandom_range(0, 3)));
                nb = int'($urandom_range(1, 3));
                for (int i = 0; i < nb; i++) begin
                    if ($urandom_range(0, 3) == 0) pq.push_back(16'hC0E0 | 16'($urandom_range(0, 3)));
                    else pq.push_back(rand_dp());
                end
                pq.push_back(16'hC0C0);
            end
        end
        pq.push_back(16'hC080);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        m_act = 0; m_cnt = 0; m_start = 0; last_op = '0;
        set_lat(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_execute", 32'(execute), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(prog_req), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr", 32'(prog_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pq = '{16'h0105, 16'h4000, 16'hC080};
        run_program(0, 0);
        run_program(3, 1);
        pq = '{16'hC0A2, 16'h4000, 16'hC0C0, 16'hC080};
        run_program(0, 0);
        pq = '{16'h4000, 16'hC0E4, 16'h4004, 16'hC080};
        run_program(0, 0);
        pq = '{16'hC100, 16'h4000, 16'hC080};
        run_program(0, 0);

        do_abort(5);
        do_abort(0);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_req", 32'(prog_req), 32'd0);
        pq = '{16'h0105, 16'h4000, 16'hC080};
        run_program(0, 0);

        // asynchronous reset in the middle of an ISSUE cycle
        load_prog();
        set_lat(0);
        @(negedge clk);
        fidx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (execute) seen = 1;
            else @(negedge clk);
        end
        check("rst_saw_exec", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_execute", 32'(execute), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_act = 0; m_cnt = 0; m_start = 0; last_op = '0;
        run_program(0, 0);

        // no END anywhere: the last address terminates the program
        pq.delete();
        for (int i = 0; i < 256; i++) pq.push_back(rand_dp());
        run_program(-1, 0);

        for (int r = 0; r < 10; r++) begin
            gen_random();
            run_program(-1, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Sequences the shared opcode bus that drives every GPU core. Fetches 16-bit instructions from an external program memory over a valid handshake and broadcasts datapath instructions with a one-cycle execute strobe.
- Consumes a small set of control instructions itself: END, LOOP_SET, LOOP_END and WAIT. These are never broadcast.
- Sits between the frame/pixel controller (start, done) and the core array (opcode, execute).

Parameters:
ADDR_WIDTH, 8, program counter / program memory address width
START_ADDR, 0, program address loaded into the PC on start

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  pulse, begin program at START_ADDR; ignored while busy
abort  input  1  synchronous; stop program, return to IDLE
prog_addr  output  ADDR_WIDTH  program memory read address (= pc)
prog_req  output  1  read request, held until prog_valid
prog_data  input  16  instruction word, valid when prog_valid
prog_valid  input  1  read data valid, 0..N cycles after prog_req
opcode  output  16  broadcast opcode to cores
execute  output  1  one-cycle strobe, cores act on opcode
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when program terminates normally
pc  output  ADDR_WIDTH  current program counter, for debug

Behaviour:
- Reset (async, rst=1): all outputs go to 0.
  - State=IDLE; pc, loop_start, loop_cnt, wait_cnt and loop_active all 0.
- Control instruction is defined as: prog_data[15:14]=2'b11 and [8]=0 and [7]=1. Sub-op is [6:5]:
  - 00 = END.
  - 01 = LOOP_SET: loop_cnt<=[4:0], loop_start<=pc+1, loop_active<=1.
  - 10 = LOOP_END.
  - 11 = WAIT with count n=[4:0].
- Every other word, including local store (class 11 with [8]=1), is a datapath instruction.
- States: IDLE, FETCH, ISSUE, WAIT.
- IDLE:
  - start=1 -> pc<=START_ADDR, FETCH.
- FETCH:
  - prog_req=1, prog_addr=pc.
  - prog_valid=0 -> stay.
  - prog_valid=1 with a datapath word -> opcode<=prog_data, ISSUE.
  - prog_valid=1 with a control word -> handle the control word in the same cycle; opcode is unchanged.
- ISSUE:
  - execute=1 for exactly this cycle. opcode is stable and is held after ISSUE until the next issue.
  - pc<=pc+1, then FETCH.
- Control word handling:
  - END: done=1 for the next cycle; then IDLE.
  - LOOP_SET: pc+1, FETCH.
  - LOOP_END with loop_active and loop_cnt!=0: loop_cnt-1, pc<=loop_start, FETCH.
  - LOOP_END with loop_cnt==0: loop_active<=0, pc+1, FETCH.
  - LOOP_END with no loop active: NOP (pc+1).
  - WAIT n=0: NOP.
  - WAIT n>0: wait_cnt<=n, WAIT state.
- WAIT:
  - execute=0 and prog_req=0; wait_cnt decrements each cycle.
  - On reaching 1, pc+1 and go to FETCH. Total stall is n cycles.
- Loop semantics:
  - The body runs loop_cnt+1 times.
  - Only a single loop level exists; a LOOP_SET while a loop is active overwrites it.
- Best-case throughput: 2 cycles per datapath instruction (FETCH with immediate valid, then ISSUE). A control instruction costs 1 cycle.
- PC end of memory: if the word at address 2^ADDR_WIDTH-1 is not END and not a taken LOOP_END, it is treated as an implicit END after its own issue. done pulses and the PC does not wrap.
- abort:
  - Has priority over everything, in any state.
  - Next state is IDLE, execute=0, prog_req=0, loop_active<=0, and no done pulse.
  - A prog_valid arriving in the abort cycle is discarded.
- start while busy: ignored. start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- Reset mid-program: immediate return to the reset values. A pending memory read is abandoned; a late prog_valid in IDLE is ignored.
- prog_valid outside FETCH: ignored.

Decomposition:
- Shared package holds:
  - opcode class constants (LOAD=00, ALU2=01, ALU1=10, MISC=11);
  - the control sub-op encodings (END, LOOP_SET, LOOP_END, WAIT);
  - field positions: class [15:14], store bit [8], control flag [7], sub-op [6:5], immediate [4:0];
  - the state encoding.
- One natural sub-module, seq_loop_unit: holds loop_start, loop_cnt and loop_active, and outputs the next-pc/branch decision for LOOP_SET and LOOP_END. The FSM, fetch handshake and wait counter stay in core_sequencer.

Test Plan:
- Straight line: program at 0 is 0x0105 (load), 0x4000 (add), 0xC080 (END), prog_valid same cycle. Required response:
  - execute pulses at cycles 2 and 4 after start, with opcode 0x0105 then 0x4000;
  - done pulses once; busy then falls; no execute for 0xC080.
- Memory latency: prog_valid delayed 3 cycles on each fetch. Required response: prog_req and prog_addr held stable throughout; the same opcode sequence is issued with no duplicate execute.
- Loop: program is LOOP_SET n=2 (0xC0A2), 0x4000, LOOP_END (0xC0C0), END. Required response: exactly 3 execute pulses with opcode 0x4000, then done.
- WAIT: program is 0x4000, WAIT n=4 (0xC0E4), 0x4004, END. Required response: 4 extra cycles with prog_req=0 and execute=0 between the two issues.
- Local store and abort:
  - 0xC100 (store, [8]=1) must be broadcast with execute=1.
  - Assert abort during a FETCH wait: next cycle busy=0, prog_req=0, no done pulse.
  - A following start runs from START_ADDR again.
- Async reset: assert rst mid-ISSUE between clock edges. Required response: execute, busy and opcode are 0 immediately; start is accepted after rst releases.
